pc_redirect_unit: RTL

- Parametrised successor to the RV32I program counter: generates fetch addresses with a valid/ready handshake to instruction memory.
- Adds stall, PC-relative and absolute redirects, a misaligned-target trap and trap return.
- Sits between decode/execute (redirect requests) and the instruction-fetch port.
- Emits a flush pulse so the pipeline can squash wrong-path instructions.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_redirect_unit_if.sv | 8 +
 rtl/pc_target_calc.sv | 29 ++
 rtl/pc_redirect_unit.sv | 61 ++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared redirect/state types and default vectors for the fetch PC unit.
package pc_pkg;
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        BRANCH   = 3'd1,
        JUMP_ABS = 3'd2,
        TRAP     = 3'd3,
        RET      = 3'd4
    } redirect_e;
    typedef enum logic [1:0] {BOOT, RUN, BUBBLE} pc_state_e;
    localparam int          DEF_DATA_W     = 32;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0100;
    localparam int          DEF_STEP       = 4;
    localparam int          DEF_ALIGN_BITS = 2;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch-address handshake between the PC unit and instruction memory.
interface pc_redirect_unit_if import pc_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
    logic              FetchValid;
    logic              FetchReady;
    logic [DATA_W-1:0] ProgAddr;
    modport master(output FetchValid, ProgAddr, input FetchReady);
    modport slave(input FetchValid, ProgAddr, output FetchReady);
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target, misalignment flag and link address.
module pc_target_calc import pc_pkg::*; #(
    parameter int              DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] TRAP_VEC = DATA_W'(DEF_TRAP_VEC),
    parameter int              STEP       = DEF_STEP,
    parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] epc,
    output logic [DATA_W-1:0] target,
    output logic              taken,
    output logic              misalign,
    output logic [DATA_W-1:0] link
);
    localparam logic [DATA_W-1:0] MASK = (DATA_W'(1) << ALIGN_BITS) - DATA_W'(1);
    logic [DATA_W-1:0] sum, rel;
    logic              is_rel;
    assign sum      = base + offset;
    // JALR discards bit 0 before the alignment check
    assign rel      = mode == BRANCH ? sum : {sum[DATA_W-1:1], 1'b0};
    assign is_rel   = mode == BRANCH || mode == JUMP_ABS;
    assign misalign = is_rel && |(rel & MASK);
    assign taken    = is_rel || mode == TRAP || mode == RET;
    assign target   = misalign ? TRAP_VEC : is_rel ? rel : mode == TRAP ? TRAP_VEC : epc;
    assign link     = prog_addr + DATA_W'(STEP);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC generator with stall, redirects, misalign trap and trap return.
module pc_redirect_unit import pc_pkg::*; #(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VEC  = DATA_W'(DEF_RESET_VEC),
    parameter logic [DATA_W-1:0] TRAP_VEC   = DATA_W'(DEF_TRAP_VEC),
    parameter int                STEP       = DEF_STEP,
    parameter int                ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Stall,
    input  logic [2:0]           RedirMode,
    input  logic [DATA_W-1:0]    RedirBase,
    input  logic [DATA_W-1:0]    RedirOffset,
    pc_redirect_unit_if.master   fetch,
    output logic [DATA_W-1:0]    LinkAddr,
    output logic [DATA_W-1:0]    EpcOut,
    output logic                 Flush,
    output logic                 MisalignErr
);
    pc_state_e         state, state_nx;
    logic [DATA_W-1:0] prog_addr, target;
    logic              taken, misalign, take, valid;
    pc_target_calc #(
        .DATA_W(DATA_W), .TRAP_VEC(TRAP_VEC), .STEP(STEP), .ALIGN_BITS(ALIGN_BITS)
    ) u_calc (
        .mode(RedirMode), .base(RedirBase), .offset(RedirOffset),
        .prog_addr(prog_addr), .epc(EpcOut),
        .target(target), .taken(taken), .misalign(misalign), .link(LinkAddr)
    );
    // redirects only count once the boot cycle has passed
    assign take             = state != BOOT && taken;
    assign valid            = state == RUN;
    assign fetch.FetchValid = valid;
    assign fetch.ProgAddr   = prog_addr;
    always_comb begin
        state_nx = RUN;
        if (take) state_nx = BUBBLE;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= BOOT;
        else state <= state_nx;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prog_addr   <= RESET_VEC;
            EpcOut      <= '0;
            Flush       <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            Flush       <= take;
            MisalignErr <= take && misalign;
            if (take) begin
                prog_addr <= target;
                EpcOut    <= misalign ? RedirBase : RedirMode == TRAP ? prog_addr : EpcOut;
            end else if (!Stall && valid && fetch.FetchReady) begin
                prog_addr <= LinkAddr;
            end
        end
    end
endmodule
